// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// byte-lane geometry and wait-counter width.
package dmem_responder_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BE_WIDTH   = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-port bus: valid/ready request channel plus a one-cycle response strobe.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port backing RAM, DEPTH_WORDS x 32, per-byte write enables, registered read.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [BE_WIDTH-1:0]      we,
  input  logic [IDX_W-1:0]         addr,
  input  logic [BE_WIDTH-1:0][7:0] wdata,
  output logic [BE_WIDTH-1:0][7:0] rdata
);

  logic [BE_WIDTH-1:0][7:0] mem [DEPTH_WORDS];

  // Read returns the pre-write word; the responder never reads and writes in one access.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_WIDTH; i++)
        if (we[i]) mem[addr][i] <= wdata[i];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request in flight,
// WAIT_CYCLES programmable wait states, one response per accepted request.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_LSB = $clog2(WORD_BYTES);
  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int WADDR_W = ADDR_WIDTH - IDX_LSB;
  localparam logic [CNT_W-1:0]   CNT_INIT  = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam logic [WADDR_W-1:0] DEPTH_LIM = WADDR_W'(DEPTH_WORDS);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  state_e                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  req_t                  req_q;
  logic                  err_q, err_c;
  logic [DATA_WIDTH-1:0] rdata_hold, ram_q, resp_word;
  logic                  accept;
  logic                  ram_en;
  logic [BE_WIDTH-1:0]   ram_we;

  assign accept = bus.req_valid && (state == ST_IDLE);

  // Range check uses the full word address so high-bit aliases are rejected.
  assign err_c = (req_q.addr[IDX_LSB-1:0] != '0) ||
                 (req_q.addr[ADDR_WIDTH-1:IDX_LSB] >= DEPTH_LIM);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) state_nxt = ST_ACCESS;
          else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (cnt == '0) state_nxt = ST_ACCESS;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = !rst;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_q      <= '0;
      err_q      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_q <= '{we: bus.req_we, addr: bus.req_addr,
                              wdata: bus.req_wdata, be: bus.req_be};
      if (state == ST_ACCESS) err_q      <= err_c;
      if (state == ST_RESP)   rdata_hold <= resp_word;
    end
  end

  assign ram_en = (state == ST_ACCESS) && !rst;
  assign ram_we = (req_q.we && !err_c) ? req_q.be : '0;

  dmem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (req_q.addr[IDX_LSB +: IDX_W]),
    .wdata (req_q.wdata),
    .rdata (ram_q)
  );

  // RAM data lands during RESP; the hold register keeps it visible afterwards.
  assign resp_word     = (req_q.we || err_q) ? '0 : ram_q;
  assign bus.rsp_rdata = (state == ST_RESP) ? resp_word : rdata_hold;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven with directed and
// random requests against a word-array model, plus a WAIT_CYCLES=0 instance
// for back-to-back throughput.
module tb_dmem_responder;

  localparam int WA = 2;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] mdl [16];

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WA))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd1024);
  endfunction

  // One request on DUT A, entered and left on a falling edge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input string tag);
    logic        er;
    logic [31:0] rd;
    int          w, lat, rdy_seen;
    er = exp_err(addr);
    rd = (er || we) ? 32'h0 : mdl[addr[5:2]];
    ifa.req_valid = 1'b1;
    ifa.req_we    = we;
    ifa.req_addr  = addr;
    ifa.req_wdata = wdata;
    ifa.req_be    = be;
    w = 0;
    while (ifa.req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk({tag, "/accept"}, 32'(w < 20), 32'd1);
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    ifa.req_we    = 1'($urandom);
    ifa.req_addr  = $urandom;
    ifa.req_wdata = $urandom;
    ifa.req_be    = 4'($urandom);
    lat = 0; rdy_seen = 0;
    do begin
      @(negedge clk); lat++;
      if (ifa.req_ready === 1'b1) rdy_seen++;
    end while (ifa.rsp_valid !== 1'b1 && lat < 20);
    chk({tag, "/latency"}, 32'(lat), 32'(WA + 2));
    chk({tag, "/busy_ready"}, 32'(rdy_seen), 32'd0);
    chk({tag, "/rdata"}, ifa.rsp_rdata, rd);
    chk({tag, "/err"}, 32'(ifa.rsp_err), 32'(er));
    @(negedge clk);
    chk({tag, "/pulse"}, 32'(ifa.rsp_valid), 32'd0);
    chk({tag, "/ready_back"}, 32'(ifa.req_ready), 32'd1);
    chk({tag, "/hold"}, ifa.rsp_rdata, rd);
    if (we && !er)
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[addr[5:2]][8*i +: 8] = wdata[8*i +: 8];
  endtask

  initial begin
    int          seen, r;
    logic [31:0] ad;

    // Reset with a load held valid: nothing may be accepted.
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.req_valid = 1'b1; ifa.req_we = 1'b0; ifa.req_addr = 32'h0;
    ifa.req_wdata = 32'h0; ifa.req_be = 4'hF;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = 32'h0;
    ifb.req_wdata = 32'h0; ifb.req_be = 4'h0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst/ready", 32'(ifa.req_ready), 32'd1);
      chk("rst/rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    end
    chk("rst/rdata", ifa.rsp_rdata, 32'h0);
    chk("rst/err", 32'(ifa.rsp_err), 32'd0);
    rst_a = 1'b0; ifa.req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.rsp_valid === 1'b1) seen++;
    end
    chk("rst/no_accept", 32'(seen), 32'd0);

    for (int k = 0; k < 16; k++) xact(1'b1, 32'(k * 4), $urandom, 4'hF, "init");

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
    xact(1'b0, 32'h10, $urandom, 4'hF, "ld10");
    chk("ld10/const", mdl[4], 32'hDEADBEEF);
    xact(1'b1, 32'h10, 32'h000000AA, 4'b0001, "st_lane0");
    xact(1'b0, 32'h10, $urandom, 4'h0, "ld_lane0");
    xact(1'b1, 32'h10, $urandom, 4'b0000, "st_be0");
    xact(1'b0, 32'h10, $urandom, 4'hF, "ld_be0");
    chk("ld_be0/const", mdl[4], 32'hDEADBEAA);
    xact(1'b0, 32'h13, $urandom, 4'hF, "ld_misal");
    xact(1'b1, 32'h1000, $urandom, 4'hF, "st_oor");
    xact(1'b0, 32'h0, $urandom, 4'hF, "ld_w0");

    // Reset while BUSY: the store must be dropped and no response issued.
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 32'h20;
    ifa.req_wdata = 32'h12345678; ifa.req_be = 4'hF;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    chk("rst_mid/ready", 32'(ifa.req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.rsp_valid === 1'b1) seen++;
    end
    chk("rst_mid/no_rsp", 32'(seen), 32'd0);
    xact(1'b0, 32'h20, $urandom, 4'hF, "rst_mid/ld");

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      ad = {26'd0, 4'($urandom), 2'b00};
      else if (r < 8) ad = {26'd0, 4'($urandom), 2'($urandom_range(1, 3))};
      else            ad = 32'($urandom_range(1024, 1048576)) << 2;
      xact(1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom), "rnd");
    end

    // WAIT_CYCLES=0: valid held high, one transfer every 3 cycles.
    rst_b = 1'b0;
    ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_addr = 32'h4;
    ifb.req_wdata = 32'hCAFEF00D; ifb.req_be = 4'hF;
    for (int i = 0; i < 12; i++) begin
      chk("b2b/ready", 32'(ifb.req_ready), 32'(i % 3 == 0));
      chk("b2b/rsp_valid", 32'(ifb.rsp_valid), 32'(i % 3 == 2));
      if (i % 3 == 2) begin
        chk("b2b/rdata", ifb.rsp_rdata, (i == 2) ? 32'h0 : 32'hCAFEF00D);
        chk("b2b/err", 32'(ifb.rsp_err), 32'd0);
      end
      if (i == 1) ifb.req_we = 1'b0;
      @(negedge clk);
    end
    ifb.req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
